// File: rtl/eth_clk_rst_seq.sv
// MMCM reset sequencer and lock supervisor: pulses the MMCM reset, waits for a stable lock, then releases the datapath reset.
// Optional event counters are enabled by defining ETH_CLK_RST_STATS_EN.
module eth_clk_rst_seq #(
  parameter int SYNC_STAGES     = 2,
  parameter int MMCM_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 100000,
  parameter int HOLDOFF_CYCLES  = 1024,
  parameter int CNT_W           = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             locked_async_in,
  input  logic             clr_cnt_in,
  output logic             mmcm_rst_o,
  output logic             eth_rst_o,
  output logic             ready_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] lock_loss_cnt_o,
  output logic [CNT_W-1:0] timeout_cnt_o
);

  localparam int MAX_A   = (MMCM_RST_CYCLES > LOCK_TIMEOUT) ? MMCM_RST_CYCLES : LOCK_TIMEOUT;
  localparam int TMR_MAX = (MAX_A > HOLDOFF_CYCLES) ? MAX_A : HOLDOFF_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_RST  = TMR_W'(MMCM_RST_CYCLES);
  localparam logic [TMR_W-1:0] TMR_WAIT = TMR_W'(LOCK_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_HOLD = TMR_W'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {RST_MMCM, WAIT_LOCK, HOLDOFF, RUN} state_e;

  state_e                 state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   timeout_evt, loss_evt;
  logic                   mmcm_rst_q, eth_rst_q, ready_q, timeout_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], locked_async_in};
  end
  assign lock_s = sync_q[SYNC_STAGES-1];

  // Timer counts down to 1; every transition reloads it for the state being entered.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q - TMR_ONE;
    timeout_evt = 1'b0;
    loss_evt    = 1'b0;
    case (state_q)
      RST_MMCM: begin
        if (tmr_q == TMR_ONE) begin
          state_d = WAIT_LOCK;
          tmr_d   = TMR_WAIT;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = HOLDOFF;
          tmr_d   = TMR_HOLD;
        end else if (tmr_q == TMR_ONE) begin
          state_d     = RST_MMCM;
          tmr_d       = TMR_RST;
          timeout_evt = 1'b1;
        end
      end
      HOLDOFF: begin
        if (!lock_s) begin
          state_d = RST_MMCM;
          tmr_d   = TMR_RST;
        end else if (tmr_q == TMR_ONE) begin
          state_d = RUN;
          tmr_d   = '0;
        end
      end
      RUN: begin
        tmr_d = tmr_q;
        if (!lock_s) begin
          state_d  = RST_MMCM;
          tmr_d    = TMR_RST;
          loss_evt = 1'b1;
        end
      end
      default: begin
        state_d = RST_MMCM;
        tmr_d   = TMR_RST;
      end
    endcase
  end

  // Outputs are decoded from the next state so they come straight from flops.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= RST_MMCM;
      tmr_q      <= TMR_RST;
      mmcm_rst_q <= 1'b1;
      eth_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      mmcm_rst_q <= (state_d == RST_MMCM);
      eth_rst_q  <= (state_d != RUN);
      ready_q    <= (state_d == RUN);
      timeout_q  <= timeout_evt;
    end
  end

  assign mmcm_rst_o = mmcm_rst_q;
  assign eth_rst_o  = eth_rst_q;
  assign ready_o    = ready_q;
  assign timeout_o  = timeout_q;

`ifdef ETH_CLK_RST_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] loss_cnt_q, to_cnt_q;

  // Clear has priority over a coincident increment; both counters saturate.
  always_ff @(posedge clk_in) begin
    if (rst_in || clr_cnt_in) begin
      loss_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      if (loss_evt && loss_cnt_q != CNT_MAX) loss_cnt_q <= loss_cnt_q + CNT_ONE;
      if (timeout_evt && to_cnt_q != CNT_MAX) to_cnt_q <= to_cnt_q + CNT_ONE;
    end
  end

  assign lock_loss_cnt_o = loss_cnt_q;
  assign timeout_cnt_o   = to_cnt_q;
`else
  logic stats_unused;
  assign stats_unused    = clr_cnt_in ^ loss_evt;
  assign lock_loss_cnt_o = '0;
  assign timeout_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_eth_clk_rst_seq.sv
// Directed plus randomized bench for eth_clk_rst_seq against a phase/elapsed-time reference model.
module tb_eth_clk_rst_seq;

  localparam int MRC = 4;
  localparam int LTO = 50;
  localparam int HOC = 8;
  localparam int SS  = 2;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef ETH_CLK_RST_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_in, locked_async_in, clr_cnt_in;
  logic          mmcm_rst_o, eth_rst_o, ready_o, timeout_o;
  logic [CW-1:0] lock_loss_cnt_o, timeout_cnt_o;

  always #5 clk_in = ~clk_in;

  eth_clk_rst_seq #(
    .SYNC_STAGES(SS), .MMCM_RST_CYCLES(MRC), .LOCK_TIMEOUT(LTO),
    .HOLDOFF_CYCLES(HOC), .CNT_W(CW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .locked_async_in(locked_async_in),
    .clr_cnt_in(clr_cnt_in), .mmcm_rst_o(mmcm_rst_o), .eth_rst_o(eth_rst_o),
    .ready_o(ready_o), .timeout_o(timeout_o),
    .lock_loss_cnt_o(lock_loss_cnt_o), .timeout_cnt_o(timeout_cnt_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase 0=reset pulse, 1=waiting for lock, 2=holdoff, 3=running.
  int m_phase, m_elapsed, m_loss, m_tocnt;
  bit m_to;
  bit lock_pipe[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt_next(input int c, input bit ev, input bit clr);
    if (!STATS || clr) return 0;
    if (ev && c < CMAX) return c + 1;
    return c;
  endfunction

  task automatic model_step();
    bit ls, to_ev, loss_ev;
    to_ev = 1'b0;
    loss_ev = 1'b0;
    if (rst_in) begin
      m_phase = 0; m_elapsed = 0; m_loss = 0; m_tocnt = 0; m_to = 1'b0;
      lock_pipe.delete();
      for (int i = 0; i < SS; i++) lock_pipe.push_back(1'b0);
    end else begin
      ls = lock_pipe.pop_front();
      lock_pipe.push_back(locked_async_in);
      case (m_phase)
        0: begin
          m_elapsed++;
          if (m_elapsed == MRC) begin m_phase = 1; m_elapsed = 0; end
        end
        1: begin
          if (ls) begin m_phase = 2; m_elapsed = 0; end
          else begin
            m_elapsed++;
            if (m_elapsed == LTO) begin to_ev = 1'b1; m_phase = 0; m_elapsed = 0; end
          end
        end
        2: begin
          if (!ls) begin m_phase = 0; m_elapsed = 0; end
          else begin
            m_elapsed++;
            if (m_elapsed == HOC) m_phase = 3;
          end
        end
        default: begin
          if (!ls) begin loss_ev = 1'b1; m_phase = 0; m_elapsed = 0; end
        end
      endcase
      m_to    = to_ev;
      m_loss  = cnt_next(m_loss, loss_ev, clr_cnt_in);
      m_tocnt = cnt_next(m_tocnt, to_ev, clr_cnt_in);
    end
  endtask

  task automatic compare_all();
    chk("mmcm_rst_o", 32'(mmcm_rst_o), 32'(m_phase == 0));
    chk("eth_rst_o", 32'(eth_rst_o), 32'(m_phase != 3));
    chk("ready_o", 32'(ready_o), 32'(m_phase == 3));
    chk("timeout_o", 32'(timeout_o), 32'(m_to));
    chk("lock_loss_cnt_o", 32'(lock_loss_cnt_o), 32'(m_loss));
    chk("timeout_cnt_o", 32'(timeout_cnt_o), 32'(m_tocnt));
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    compare_all();
  endtask

  initial begin
    int n, last, pulses, dwell;
    rst_in = 1'b1; locked_async_in = 1'b0; clr_cnt_in = 1'b0;

    // Power-up: reset pulse length and lock-to-release latency.
    repeat (3) tick();
    chk("reset_mmcm", 32'(mmcm_rst_o), 32'd1);
    chk("reset_ready", 32'(ready_o), 32'd0);
    rst_in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("pwrup_mmcm_hold", 32'(mmcm_rst_o), 32'(i < 4));
    end
    repeat (16) tick();
    locked_async_in = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk("pwrup_eth_rst", 32'(eth_rst_o), 32'(i < 11));
      chk("pwrup_ready", 32'(ready_o), 32'(i == 11));
    end

    // Reset while running.
    rst_in = 1'b1;
    tick();
    chk("rst_run_mmcm", 32'(mmcm_rst_o), 32'd1);
    chk("rst_run_eth", 32'(eth_rst_o), 32'd1);
    chk("rst_run_ready", 32'(ready_o), 32'd0);
    chk("rst_run_to", 32'(timeout_o), 32'd0);

    // Lock never arrives: timeout cadence and saturation.
    locked_async_in = 1'b0;
    tick();
    rst_in = 1'b0;
    last = 0; pulses = 0;
    for (n = 1; n <= 16 * 54 + 20 && pulses < 16; n++) begin
      tick();
      if (timeout_o === 1'b1) begin
        pulses++;
        chk("timeout_spacing", 32'(n - last), 32'd54);
        chk("timeout_cnt", 32'(timeout_cnt_o), STATS ? 32'((pulses < CMAX) ? pulses : CMAX) : 32'd0);
        last = n;
      end
    end
    chk("timeout_pulses", 32'(pulses), 32'd16);

    // Lock drop during holdoff.
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    repeat (10) tick();
    locked_async_in = 1'b1;
    repeat (5) tick();
    locked_async_in = 1'b0;
    repeat (2) tick();
    chk("holdoff_pre_drop", 32'(mmcm_rst_o), 32'd0);
    tick();
    chk("holdoff_drop_rst", 32'(mmcm_rst_o), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("holdoff_eth", 32'(eth_rst_o), 32'd1);
      chk("holdoff_loss_cnt", 32'(lock_loss_cnt_o), 32'd0);
    end

    // Lock loss in RUN, then re-lock.
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    locked_async_in = 1'b1;
    repeat (30) tick();
    chk("run_reached", 32'(ready_o), 32'd1);
    locked_async_in = 1'b0;
    repeat (2) tick();
    chk("loss_eth_pre", 32'(eth_rst_o), 32'd0);
    tick();
    chk("loss_eth", 32'(eth_rst_o), 32'd1);
    chk("loss_mmcm", 32'(mmcm_rst_o), 32'd1);
    chk("loss_cnt", 32'(lock_loss_cnt_o), STATS ? 32'd1 : 32'd0);
    locked_async_in = 1'b1;
    repeat (30) tick();
    chk("relock_ready", 32'(ready_o), 32'd1);

    // Clear coinciding with a lock-loss increment.
    locked_async_in = 1'b0;
    repeat (2) tick();
    clr_cnt_in = 1'b1;
    tick();
    clr_cnt_in = 1'b0;
    chk("clr_vs_inc", 32'(lock_loss_cnt_o), 32'd0);
    chk("clr_eth", 32'(eth_rst_o), 32'd1);

    // Randomized lock activity with sporadic clears and resets.
    dwell = 0;
    for (int i = 0; i < 3000; i++) begin
      if (dwell == 0) begin
        locked_async_in = ~locked_async_in;
        dwell = $urandom_range(1, 90);
      end
      dwell--;
      clr_cnt_in = ($urandom_range(0, 63) == 0);
      rst_in     = ($urandom_range(0, 699) == 0);
      tick();
    end
    rst_in = 1'b0; clr_cnt_in = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
